// File: rtl/itrx_aib_phy_repair_pkg.sv
// Shared types and constants for the AIB repair-row loader.
// ITRX_AIB_PHY_REPAIR_PAR_EN widens NVM rows to 13 bits (bit 12 = even parity).
package itrx_aib_phy_repair_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        NEXT,
        DONE
    } repair_st_e;

    // Row layout as read from NVM
    localparam int unsigned RVLD_BIT = 11;
    localparam int unsigned DIR_BIT  = 10;
    localparam int unsigned IDX_MSB  = 9;

    localparam logic [9:0] MAX_IDX_DEF = 10'd21;

`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    localparam int unsigned NVM_DW = 13;
`else
    localparam int unsigned NVM_DW = 12;
`endif

    // {dir, index[9:0]} as handed to a channel repair encoder
    typedef logic [10:0] repair_row_t;

endpackage

// File: rtl/itrx_aib_phy_repair_ctl_if.sv
// NVM read port between the repair loader (master) and the fuse/NVM controller (slave).
// nvm_rdata width follows ITRX_AIB_PHY_REPAIR_PAR_EN through the package.
interface itrx_aib_phy_repair_ctl_if #(
    parameter int unsigned ADDRW = 8
);
    import itrx_aib_phy_repair_pkg::*;

    logic              nvm_req;
    logic [ADDRW-1:0]  nvm_addr;
    logic              nvm_ack;
    logic [NVM_DW-1:0] nvm_rdata;

    modport master (output nvm_req, nvm_addr, input nvm_ack, nvm_rdata);
    modport slave  (input nvm_req, nvm_addr, output nvm_ack, nvm_rdata);

endinterface

// File: rtl/itrx_aib_phy_repair_row_chk.sv
// Combinational validity / range / parity check of one NVM repair row.
// ITRX_AIB_PHY_REPAIR_PAR_EN adds the parity check and par_err_o.
module itrx_aib_phy_repair_row_chk
    import itrx_aib_phy_repair_pkg::*;
#(
    parameter logic [9:0] MAX_IDX = MAX_IDX_DEF
) (
    input  logic [NVM_DW-1:0] rdata_i,
    output logic              row_vld_o,
    output logic              row_ok_o,
    output logic              row_err_o,
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    output logic              par_err_o,
`endif
    output repair_row_t       row_o
);
    logic range_err;
    logic par_err;

    assign row_vld_o = rdata_i[RVLD_BIT];
    assign row_o     = rdata_i[DIR_BIT:0];
    assign range_err = rdata_i[RVLD_BIT] && (rdata_i[IDX_MSB:0] > MAX_IDX);

`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    // Even parity: stored bit must equal XOR of the 12 data bits
    assign par_err   = rdata_i[NVM_DW-1] != (^rdata_i[NVM_DW-2:0]);
    assign par_err_o = par_err;
`else
    assign par_err   = 1'b0;
`endif

    assign row_err_o = range_err | par_err;
    assign row_ok_o  = rdata_i[RVLD_BIT] & ~row_err_o;

endmodule

// File: rtl/itrx_aib_phy_repair_ctl.sv
// AIB repair-row loader: walks channels 0..MAXCH-1 over the NVM req/ack port,
// range-checks each row and holds the rows for the channel repair encoders.
// Optional: ITRX_AIB_PHY_REPAIR_PAR_EN (row parity, adds repair_par_err).
module itrx_aib_phy_repair_ctl
    import itrx_aib_phy_repair_pkg::*;
#(
    parameter int unsigned      MAXCH     = 32'd1,
    parameter int unsigned      ADDRW     = 8,
    parameter logic [ADDRW-1:0] BASE_ADDR = 8'h00,
    parameter logic [15:0]      TMO_CYC   = 16'd255,
    parameter logic [9:0]       MAX_IDX   = MAX_IDX_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      repair_start,
    itrx_aib_phy_repair_ctl_if.master nvm,
    output logic [MAXCH-1:0][10:0]    repair_info_nvm,
    output logic [MAXCH-1:0]          repair_info_vld,
    output logic                      repair_busy,
    output logic                      repair_done,
    output logic                      repair_err,
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    output logic                      repair_par_err,
`endif
    output logic [4:0]                repair_err_ch
);
    localparam int unsigned    CHW     = (MAXCH > 1) ? $clog2(MAXCH) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(MAXCH - 1);

    repair_st_e             state_q, state_d;
    logic [CHW-1:0]         ch_q, ch_d;
    logic [15:0]            cnt_q, cnt_d, cnt_inc;
    logic [MAXCH-1:0][10:0] info_q, info_d;
    logic [MAXCH-1:0]       vld_q, vld_d;
    logic                   err_q, err_d;
    logic [4:0]             err_ch_q, err_ch_d;
    logic                   raise;
    logic                   tmo;
    logic                   row_vld, row_ok, row_err;
    repair_row_t            row;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    logic                   par_err;
    logic                   par_q, par_d;
`endif

    itrx_aib_phy_repair_row_chk #(.MAX_IDX(MAX_IDX)) u_row_chk (
        .rdata_i   (nvm.nvm_rdata),
        .row_vld_o (row_vld),
        .row_ok_o  (row_ok),
        .row_err_o (row_err),
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
        .par_err_o (par_err),
`endif
        .row_o     (row)
    );

    assign cnt_inc = cnt_q + 16'd1;
    assign tmo     = (cnt_inc == TMO_CYC);

    // State register and all held results; async reset returns everything to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            info_q   <= '0;
            vld_q    <= '0;
            err_q    <= 1'b0;
            err_ch_q <= '0;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            info_q   <= info_d;
            vld_q    <= vld_d;
            err_q    <= err_d;
            err_ch_q <= err_ch_d;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
            par_q    <= par_d;
`endif
        end
    end

    // Next-state: channel walk, row capture and sticky error bookkeeping
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        info_d   = info_q;
        vld_d    = vld_q;
        err_d    = err_q;
        err_ch_d = err_ch_q;
        raise    = 1'b0;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                // Rows are kept; only validity and status restart
                if (repair_start) begin
                    state_d  = REQ;
                    ch_d     = '0;
                    cnt_d    = '0;
                    vld_d    = '0;
                    err_d    = 1'b0;
                    err_ch_d = '0;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
                    par_d    = 1'b0;
`endif
                end
            end
            REQ: state_d = WAIT;
            WAIT: begin
                cnt_d = cnt_inc;
                // Ack takes priority over a timeout landing in the same cycle
                if (nvm.nvm_ack) begin
                    state_d = NEXT;
                    if (row_vld) info_d[ch_q] = row;
                    vld_d[ch_q] = row_ok;
                    raise = row_err;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
                    if (par_err) par_d = 1'b1;
`endif
                end else if (tmo) begin
                    state_d     = NEXT;
                    vld_d[ch_q] = 1'b0;
                    raise       = 1'b1;
                end
            end
            NEXT: begin
                if (ch_q == LAST_CH) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + CHW'(1);
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        // Channel of the first error only
        if (raise && !err_q) begin
            err_d    = 1'b1;
            err_ch_d = 5'(ch_q);
        end
    end

    assign nvm.nvm_req  = (state_q == REQ) || (state_q == WAIT);
    assign nvm.nvm_addr = nvm.nvm_req ? (BASE_ADDR + ADDRW'(ch_q)) : '0;

    assign repair_info_nvm = info_q;
    assign repair_info_vld = vld_q;
    assign repair_busy     = (state_q == REQ) || (state_q == WAIT) || (state_q == NEXT);
    assign repair_done     = (state_q == DONE);
    assign repair_err      = err_q;
    assign repair_err_ch   = err_ch_q;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    assign repair_par_err  = par_q;
`endif

endmodule

// File: tb/tb_itrx_aib_phy_repair_ctl.sv
// Directed bench for itrx_aib_phy_repair_ctl: 4 channels, BASE_ADDR=0x10, 4-cycle ack timeout.
// Honours ITRX_AIB_PHY_REPAIR_PAR_EN (adds a bad-parity row case).
module tb_itrx_aib_phy_repair_ctl;
    import itrx_aib_phy_repair_pkg::*;

    localparam int unsigned MAXCH = 4;
    localparam int unsigned ADDRW = 8;
    localparam logic [7:0]  BASE  = 8'h10;
    localparam logic [15:0] TMO   = 16'd4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   repair_start;
    logic [MAXCH-1:0][10:0] info;
    logic [MAXCH-1:0]       vld;
    logic                   busy, done, err;
    logic [4:0]             err_ch;
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
    logic                   par_err;
`endif

    itrx_aib_phy_repair_ctl_if #(.ADDRW(ADDRW)) nvm ();

    itrx_aib_phy_repair_ctl #(
        .MAXCH     (MAXCH),
        .ADDRW     (ADDRW),
        .BASE_ADDR (BASE),
        .TMO_CYC   (TMO),
        .MAX_IDX   (10'd21)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .repair_start    (repair_start),
        .nvm             (nvm.master),
        .repair_info_nvm (info),
        .repair_info_vld (vld),
        .repair_busy     (busy),
        .repair_done     (done),
        .repair_err      (err),
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
        .repair_par_err  (par_err),
`endif
        .repair_err_ch   (err_ch)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // NVM model table: row per channel and the WAIT cycle in which to ack (0 = never)
    logic [NVM_DW-1:0] rows [MAXCH];
    int unsigned       dly  [MAXCH];

    function automatic logic [NVM_DW-1:0] mk(input logic [11:0] r);
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
        return {^r, r};
`else
        return r;
`endif
    endfunction

    task automatic set_ch(input int unsigned c, input logic [11:0] r, input int unsigned d);
        rows[c] = mk(r);
        dly[c]  = d;
    endtask

    // NVM responder: ack in WAIT cycle d, i.e. on the (d+1)-th cycle req is seen high
    initial begin
        int unsigned age;
        int unsigned idx;
        age = 0;
        nvm.nvm_ack   = 1'b0;
        nvm.nvm_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            nvm.nvm_ack = 1'b0;
            if (nvm.nvm_req) begin
                age++;
                idx = 32'(nvm.nvm_addr - BASE);
                if (idx < MAXCH && dly[idx] != 0 && age == dly[idx] + 1) begin
                    nvm.nvm_ack   = 1'b1;
                    nvm.nvm_rdata = rows[idx];
                end
            end else begin
                age = 0;
            end
        end
    end

    // Per-run observations, written only by the main thread
    int unsigned req_cyc [MAXCH];
    logic [7:0]  first_addr;
    logic        first_seen;
    logic        busy_at1;

    // Pulse start, then step cycles until done; cyc = cycles from the start pulse to done
    task automatic start_and_wait(input int unsigned pulse_at, output int unsigned cyc);
        int unsigned idx;
        for (int i = 0; i < MAXCH; i++) req_cyc[i] = 0;
        first_seen = 1'b0;
        first_addr = '1;
        busy_at1   = 1'b0;
        cyc        = 0;
        @(posedge clk);
        #1;
        repair_start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk);
            #1;
            repair_start = (pulse_at != 0) && (i == pulse_at);
            cyc = i;
            if (i == 1) busy_at1 = busy;
            if (nvm.nvm_req) begin
                idx = 32'(nvm.nvm_addr - BASE);
                if (idx < MAXCH) req_cyc[idx]++;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    first_addr = nvm.nvm_addr;
                end
            end
            if (done) break;
        end
        check("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        logic        hit;
        rst          = 1'b1;
        repair_start = 1'b0;
        for (int i = 0; i < MAXCH; i++) begin
            rows[i] = '0;
            dly[i]  = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld",    64'(vld),          64'd0);
        check("rst_info",   64'(info),         64'd0);
        check("rst_busy",   64'(busy),         64'd0);
        check("rst_done",   64'(done),         64'd0);
        check("rst_err",    64'(err),          64'd0);
        check("rst_err_ch", 64'(err_ch),       64'd0);
        check("rst_req",    64'(nvm.nvm_req),  64'd0);
        check("rst_addr",   64'(nvm.nvm_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // T1: mixed rows, ack in first WAIT cycle
        set_ch(0, 12'h800, 1);
        set_ch(1, 12'hC0A, 1);
        set_ch(2, 12'h000, 1);
        set_ch(3, 12'h815, 1);
        start_and_wait(0, cyc);
        check("t1_cyc",     64'(cyc),        64'd13);
        check("t1_busy1",   64'(busy_at1),   64'd1);
        check("t1_busy",    64'(busy),       64'd0);
        check("t1_vld",     64'(vld),        64'b1011);
        check("t1_info0",   64'(info[0]),    64'h000);
        check("t1_info1",   64'(info[1]),    64'h40A);
        check("t1_info2",   64'(info[2]),    64'h000);
        check("t1_info3",   64'(info[3]),    64'h015);
        check("t1_err",     64'(err),        64'd0);
        check("t1_addr0",   64'(first_addr), 64'(BASE));
        check("t1_reqc3",   64'(req_cyc[3]), 64'd2);
`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
        check("t1_par",     64'(par_err),    64'd0);
`endif

        // T2: index 22 on ch1, later timeout on ch3 must not move err_ch
        set_ch(0, 12'h800, 1);
        set_ch(1, 12'h816, 1);
        set_ch(2, 12'h805, 1);
        set_ch(3, 12'h801, 0);
        start_and_wait(0, cyc);
        check("t2_cyc",     64'(cyc),        64'd16);
        check("t2_vld",     64'(vld),        64'b0101);
        check("t2_err",     64'(err),        64'd1);
        check("t2_err_ch",  64'(err_ch),     64'd1);
        check("t2_info1",   64'(info[1]),    64'h016);
        check("t2_info2",   64'(info[2]),    64'h005);
        check("t2_info3",   64'(info[3]),    64'h015);
        check("t2_reqc3",   64'(req_cyc[3]), 64'd5);

        // T3: no ack on ch0 (timeout), ch1..3 load normally
        set_ch(0, 12'h815, 0);
        set_ch(1, 12'h80A, 1);
        set_ch(2, 12'h807, 1);
        set_ch(3, 12'h800, 1);
        start_and_wait(0, cyc);
        check("t3_cyc",     64'(cyc),        64'd16);
        check("t3_reqc0",   64'(req_cyc[0]), 64'd5);
        check("t3_addr0",   64'(first_addr), 64'(BASE));
        check("t3_err",     64'(err),        64'd1);
        check("t3_err_ch",  64'(err_ch),     64'd0);
        check("t3_vld",     64'(vld),        64'b1110);
        check("t3_info0",   64'(info[0]),    64'h000);
        check("t3_info1",   64'(info[1]),    64'h00A);

        // T4: ack on ch2 coincides with timeout; stray start while busy
        set_ch(0, 12'h800, 1);
        set_ch(1, 12'hC0A, 1);
        set_ch(2, 12'hC13, 4);
        set_ch(3, 12'h815, 1);
        start_and_wait(5, cyc);
        check("t4_cyc",     64'(cyc),        64'd16);
        check("t4_err",     64'(err),        64'd0);
        check("t4_vld",     64'(vld),        64'b1111);
        check("t4_info2",   64'(info[2]),    64'h413);
        check("t4_reqc2",   64'(req_cyc[2]), 64'd5);

        // T5: reset while waiting on ch2
        set_ch(0, 12'h800, 1);
        set_ch(1, 12'hC0A, 1);
        set_ch(2, 12'h805, 0);
        set_ch(3, 12'h815, 1);
        @(posedge clk);
        #1;
        repair_start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(posedge clk);
            #1;
            repair_start = 1'b0;
            if (nvm.nvm_req && nvm.nvm_addr == BASE + 8'd2) hit = 1'b1;
        end
        check("t5_reach_ch2", 64'(hit), 64'd1);
        @(posedge clk);
        #2;
        check("t5_pre_req",  64'(nvm.nvm_req), 64'd1);
        check("t5_pre_vld",  64'(vld),         64'b0011);
        rst = 1'b1;
        #1;
        check("t5_rst_vld",  64'(vld),          64'd0);
        check("t5_rst_info", 64'(info),         64'd0);
        check("t5_rst_busy", 64'(busy),         64'd0);
        check("t5_rst_req",  64'(nvm.nvm_req),  64'd0);
        check("t5_rst_addr", 64'(nvm.nvm_addr), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // T6: fresh load after reset starts again at ch0
        set_ch(0, 12'h800, 1);
        set_ch(1, 12'hC0A, 1);
        set_ch(2, 12'h000, 1);
        set_ch(3, 12'h815, 1);
        start_and_wait(0, cyc);
        check("t6_cyc",     64'(cyc),        64'd13);
        check("t6_addr0",   64'(first_addr), 64'(BASE));
        check("t6_vld",     64'(vld),        64'b1011);
        check("t6_info1",   64'(info[1]),    64'h40A);
        check("t6_info2",   64'(info[2]),    64'h000);
        check("t6_err",     64'(err),        64'd0);

`ifdef ITRX_AIB_PHY_REPAIR_PAR_EN
        // T7: ch0 row carries the wrong parity bit
        set_ch(1, 12'h801, 1);
        set_ch(2, 12'h802, 1);
        set_ch(3, 12'h803, 1);
        rows[0] = 13'h1801;
        dly[0]  = 1;
        start_and_wait(0, cyc);
        check("t7_vld0",    64'(vld[0]),  64'd0);
        check("t7_par",     64'(par_err), 64'd1);
        check("t7_err",     64'(err),     64'd1);
        check("t7_err_ch",  64'(err_ch),  64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
